// File: rtl/led_fade_pwm_pkg.sv
// Shared constants for the LED fade output stage.
package led_fade_pwm_pkg;

  localparam int unsigned LED_NUM      = 6;
  localparam int unsigned LED_PWM_BITS = 8;
  localparam int unsigned LED_CLK_HZ   = 50_000_000;
  localparam int unsigned DIV_W        = 32;

endpackage

// File: rtl/led_fade_pwm_if.sv
// Pattern-in / PWM-out bundle between the flow generator and the LED fade stage.
interface led_fade_pwm_if;
  import led_fade_pwm_pkg::*;

  logic [LED_NUM-1:0] led_in;
  logic [LED_NUM-1:0] led_out;

  modport master (output led_in, input led_out);
  modport slave  (input led_in, output led_out);

endinterface

// File: rtl/led_fade_channel.sv
// One LED channel: brightness register with attack/decay priority and PWM compare.
module led_fade_channel
  import led_fade_pwm_pkg::*;
#(
  parameter int unsigned              PWM_BITS   = LED_PWM_BITS,
  parameter logic [PWM_BITS-1:0]      DECAY_STEP = PWM_BITS'(8)
) (
  input  logic                clk_50m,
  input  logic                reset_n,
  input  logic                led_in,
  input  logic                tick,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  output logic                led_out
);

  localparam logic [PWM_BITS-1:0] MAX = '1;

  logic [PWM_BITS-1:0] bri;

  // Input forces full brightness; otherwise decay on tick, saturating at zero.
  always_ff @(posedge clk_50m or negedge reset_n) begin
    if (!reset_n) begin
      bri     <= '0;
      led_out <= 1'b0;
    end else begin
      if (led_in) begin
        bri <= MAX;
      end else if (tick && (bri > DECAY_STEP)) begin
        bri <= bri - DECAY_STEP;
      end else if (tick) begin
        bri <= '0;
      end
      led_out <= (bri == MAX) | (pwm_cnt < bri);
    end
  end

endmodule

// File: rtl/led_fade_pwm.sv
// PWM LED driver that turns a stepped running light into a comet with a fading tail.
module led_fade_pwm
  import led_fade_pwm_pkg::*;
#(
  parameter int unsigned          PWM_BITS   = LED_PWM_BITS,
  parameter logic [DIV_W-1:0]     DECAY_DIV  = 32'd250_000,
  parameter logic [PWM_BITS-1:0]  DECAY_STEP = PWM_BITS'(8)
) (
  input  logic          clk_50m,
  input  logic          reset_n,
  led_fade_pwm_if.slave led
);

  logic [DIV_W-1:0]    div_cnt;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                tick;
  logic [LED_NUM-1:0]  led_q;

  assign tick = (div_cnt == DECAY_DIV - DIV_W'(1));

  // Decay divider and shared free-running PWM counter.
  always_ff @(posedge clk_50m or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
      pwm_cnt <= '0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
    end
  end

  for (genvar i = 0; i < LED_NUM; i++) begin : g_ch
    led_fade_channel #(
      .PWM_BITS   (PWM_BITS),
      .DECAY_STEP (DECAY_STEP)
    ) u_ch (
      .clk_50m (clk_50m),
      .reset_n (reset_n),
      .led_in  (led.led_in[i]),
      .tick    (tick),
      .pwm_cnt (pwm_cnt),
      .led_out (led_q[i])
    );
  end

  assign led.led_out = led_q;

endmodule
